apb_i2c_regif: RTL and testbench

//  Parametrised APB3 slave register interface for the I2C core. Decodes a

---
 rtl/apb_i2c_pkg.sv | 32 +++
 rtl/apb_i2c_irq_ctrl.sv | 59 +++++
 rtl/apb_i2c_regif.sv | 154 +++++++++++++++
 tb/tb_apb_i2c_regif.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_i2c_pkg.sv
// Shared definitions for the APB register interface of the I2C core.
package apb_i2c_pkg;

  // Register byte offsets
  localparam int unsigned OFS_TXDATA   = 32'h00;
  localparam int unsigned OFS_RXDATA   = 32'h04;
  localparam int unsigned OFS_CFG      = 32'h08;
  localparam int unsigned OFS_TIMEOUT  = 32'h0C;
  localparam int unsigned OFS_STATUS   = 32'h10;
  localparam int unsigned OFS_IRQ_EN   = 32'h14;
  localparam int unsigned OFS_IRQ_STAT = 32'h18;

  // IRQ_STAT / IRQ_EN bit positions
  localparam int unsigned IRQ_TXE  = 0;
  localparam int unsigned IRQ_RXNE = 1;
  localparam int unsigned IRQ_ERR  = 2;
  localparam int unsigned IRQ_TMO  = 3;
  localparam int unsigned IRQ_W    = 4;

  // STATUS bit positions
  localparam int unsigned ST_TX_FULL  = 0;
  localparam int unsigned ST_RX_EMPTY = 1;
  localparam int unsigned ST_TX_EMPTY = 2;
  localparam int unsigned ST_ERR_LVL  = 3;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StWait
  } apb_state_e;

endpackage

// File: rtl/apb_i2c_irq_ctrl.sv
// Sticky interrupt status with edge detection, W1C clearing, masking and a registered irq.
module apb_i2c_irq_ctrl
  import apb_i2c_pkg::*;
(
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              tx_empty,
  input  logic              rx_empty,
  input  logic              core_error,
  input  logic              tmo_set,
  input  logic              en_we,
  input  logic [IRQ_W-1:0]  en_wdata,
  input  logic              stat_w1c,
  input  logic [IRQ_W-1:0]  w1c_mask,
  output logic [IRQ_W-1:0]  irq_en,
  output logic [IRQ_W-1:0]  irq_stat,
  output logic              irq
);

  logic             tx_empty_q, rx_empty_q, core_error_q;
  logic [IRQ_W-1:0] en_q, en_d, stat_q, stat_d, set;
  logic             irq_q;

  // Event detection and next-state for the enable and sticky status registers
  always_comb begin
    set           = '0;
    set[IRQ_TXE]  = tx_empty & ~tx_empty_q;
    set[IRQ_RXNE] = ~rx_empty & rx_empty_q;
    set[IRQ_ERR]  = core_error & ~core_error_q;
    set[IRQ_TMO]  = tmo_set;
    // A new event in the same cycle as its W1C keeps the bit set
    stat_d = (stat_q & ~(stat_w1c ? w1c_mask : '0)) | set;
    en_d   = en_we ? en_wdata : en_q;
  end

  // State registers; irq follows the masked status one cycle later
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tx_empty_q   <= 1'b0;
      rx_empty_q   <= 1'b0;
      core_error_q <= 1'b0;
      en_q         <= '0;
      stat_q       <= '0;
      irq_q        <= 1'b0;
    end else begin
      tx_empty_q   <= tx_empty;
      rx_empty_q   <= rx_empty;
      core_error_q <= core_error;
      en_q         <= en_d;
      stat_q       <= stat_d;
      irq_q        <= |(stat_q & en_q);
    end
  end

  assign irq_en   = en_q;
  assign irq_stat = stat_q;
  assign irq      = irq_q;

endmodule

// File: rtl/apb_i2c_regif.sv
// APB3 slave register file for the I2C core with FIFO back-pressure and wait timeout.
module apb_i2c_regif
  import apb_i2c_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned CFG_W    = 14,
  parameter int unsigned TMO_W    = 14,
  parameter int unsigned WAIT_MAX = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [DATA_W-1:0] tx_wdata,
  output logic              tx_wr_en,
  input  logic              tx_full,
  input  logic              tx_empty,
  input  logic [DATA_W-1:0] rx_rdata,
  output logic              rx_rd_en,
  input  logic              rx_empty,
  input  logic              core_error,
  output logic [CFG_W-1:0]  i2c_cfg,
  output logic [TMO_W-1:0]  i2c_timeout,
  output logic              irq
);

  localparam int unsigned CNT_W = $clog2(WAIT_MAX + 1);

  localparam logic [ADDR_W-1:0] A_TX   = ADDR_W'(OFS_TXDATA);
  localparam logic [ADDR_W-1:0] A_RX   = ADDR_W'(OFS_RXDATA);
  localparam logic [ADDR_W-1:0] A_CFG  = ADDR_W'(OFS_CFG);
  localparam logic [ADDR_W-1:0] A_TMO  = ADDR_W'(OFS_TIMEOUT);
  localparam logic [ADDR_W-1:0] A_ST   = ADDR_W'(OFS_STATUS);
  localparam logic [ADDR_W-1:0] A_IEN  = ADDR_W'(OFS_IRQ_EN);
  localparam logic [ADDR_W-1:0] A_ISTA = ADDR_W'(OFS_IRQ_STAT);

  apb_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CFG_W-1:0] cfg_q;
  logic [TMO_W-1:0] tmo_q;

  logic             active, hit_tx, hit_rx, hit_cfg, hit_tmo, hit_st, hit_ien, hit_ista;
  logic             bad, stall, timeout, wr_ok, rd_ok;
  logic [IRQ_W-1:0] irq_en, irq_stat, status;

  // Address decode, access classification and APB/FIFO outputs
  always_comb begin
    hit_tx   = (PADDR == A_TX);
    hit_rx   = (PADDR == A_RX);
    hit_cfg  = (PADDR == A_CFG);
    hit_tmo  = (PADDR == A_TMO);
    hit_st   = (PADDR == A_ST);
    hit_ien  = (PADDR == A_IEN);
    hit_ista = (PADDR == A_ISTA);
    // An abandoned transfer (PSEL or PENABLE dropped) never completes
    active  = PSEL & PENABLE & (state_q != StIdle);
    bad     = ~(hit_tx | hit_rx | hit_cfg | hit_tmo | hit_st | hit_ien | hit_ista)
              | (PWRITE & (hit_rx | hit_st)) | (~PWRITE & hit_tx);
    stall   = (PWRITE & hit_tx & tx_full) | (~PWRITE & hit_rx & rx_empty);
    timeout = stall & (cnt_q == CNT_W'(WAIT_MAX));
    PREADY  = active & (bad | ~stall | timeout);
    PSLVERR = active & (bad | timeout);
    wr_ok   = active & ~bad & ~stall & PWRITE;
    rd_ok   = active & ~bad & ~stall & ~PWRITE;
    tx_wr_en = wr_ok & hit_tx;
    rx_rd_en = rd_ok & hit_rx;
    tx_wdata = PWDATA;

    status              = '0;
    status[ST_TX_FULL]  = tx_full;
    status[ST_RX_EMPTY] = rx_empty;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_ERR_LVL]  = core_error;

    PRDATA = '0;
    if (rd_ok) begin
      case (PADDR)
        A_RX:    PRDATA = rx_rdata;
        A_CFG:   PRDATA = DATA_W'(cfg_q);
        A_TMO:   PRDATA = DATA_W'(tmo_q);
        A_ST:    PRDATA = DATA_W'(status);
        A_IEN:   PRDATA = DATA_W'(irq_en);
        A_ISTA:  PRDATA = DATA_W'(irq_stat);
        default: PRDATA = '0;
      endcase
    end
  end

  // APB transfer FSM with the stall counter
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (PSEL && !PENABLE) state_q <= StAccess;
        end
        StAccess, StWait: begin
          if (!active || PREADY) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else begin
            state_q <= StWait;
            cnt_q   <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // CFG and TIMEOUT registers; upper PWDATA bits are dropped
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cfg_q <= '0;
      tmo_q <= '0;
    end else begin
      if (wr_ok && hit_cfg) cfg_q <= PWDATA[CFG_W-1:0];
      if (wr_ok && hit_tmo) tmo_q <= PWDATA[TMO_W-1:0];
    end
  end

  assign i2c_cfg     = cfg_q;
  assign i2c_timeout = tmo_q;

  apb_i2c_irq_ctrl u_irq_ctrl (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .tx_empty   (tx_empty),
    .rx_empty   (rx_empty),
    .core_error (core_error),
    .tmo_set    (active & timeout),
    .en_we      (wr_ok & hit_ien),
    .en_wdata   (PWDATA[IRQ_W-1:0]),
    .stat_w1c   (wr_ok & hit_ista),
    .w1c_mask   (PWDATA[IRQ_W-1:0]),
    .irq_en     (irq_en),
    .irq_stat   (irq_stat),
    .irq        (irq)
  );

endmodule

// File: tb/tb_apb_i2c_regif.sv
module tb_apb_i2c_regif;

  localparam int WAIT_MAX = 16;

  logic        PCLK = 1'b0;
  logic        PRESETn, PSEL, PENABLE, PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA, PRDATA, tx_wdata, rx_rdata;
  logic        PREADY, PSLVERR, tx_wr_en, tx_full, tx_empty, rx_rd_en, rx_empty, core_error;
  logic [13:0] i2c_cfg, i2c_timeout;
  logic        irq;

  apb_i2c_regif #(
    .ADDR_W   (8),
    .DATA_W   (32),
    .CFG_W    (14),
    .TMO_W    (14),
    .WAIT_MAX (WAIT_MAX)
  ) dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PADDR       (PADDR),
    .PWDATA      (PWDATA),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR),
    .tx_wdata    (tx_wdata),
    .tx_wr_en    (tx_wr_en),
    .tx_full     (tx_full),
    .tx_empty    (tx_empty),
    .rx_rdata    (rx_rdata),
    .rx_rd_en    (rx_rd_en),
    .rx_empty    (rx_empty),
    .core_error  (core_error),
    .i2c_cfg     (i2c_cfg),
    .i2c_timeout (i2c_timeout),
    .irq         (irq)
  );

  always #5 PCLK = ~PCLK;

  int n_cmp = 0;
  int n_fail = 0;
  int tx_pulses = 0;
  int rx_pulses = 0;
  logic [31:0] last_txw = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [13:0] m_cfg, m_tmo;
  logic [3:0]  m_en, m_stat, m_set, m_clr;
  logic        m_irq, m_ptx, m_prx, m_perr, m_irq_nx;
  int          k_cnt;
  logic        acc, mapped, bad, stall, ok, tmo, e_ready, e_err;
  logic [31:0] e_rdata;

  always @(negedge PCLK) begin
    if (!PRESETn) begin
      m_cfg = '0; m_tmo = '0; m_en = '0; m_stat = '0; m_irq = 1'b0;
      m_ptx = 1'b0; m_prx = 1'b0; m_perr = 1'b0; k_cnt = 0;
    end
    acc    = PRESETn && PSEL && PENABLE;
    mapped = PADDR inside {8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18};
    bad    = !mapped || (PWRITE && (PADDR == 8'h04 || PADDR == 8'h10))
             || (!PWRITE && PADDR == 8'h00);
    stall  = !bad && ((PWRITE && PADDR == 8'h00 && tx_full)
                      || (!PWRITE && PADDR == 8'h04 && rx_empty));
    e_ready = 1'b0; e_err = 1'b0; ok = 1'b0; tmo = 1'b0; e_rdata = '0;
    if (acc) begin
      if (bad) begin
        e_ready = 1'b1; e_err = 1'b1;
      end else if (stall) begin
        if (k_cnt >= WAIT_MAX) begin
          e_ready = 1'b1; e_err = 1'b1; tmo = 1'b1;
        end
      end else begin
        e_ready = 1'b1; ok = 1'b1;
      end
    end
    if (ok && !PWRITE) begin
      case (PADDR)
        8'h04: e_rdata = rx_rdata;
        8'h08: e_rdata = {18'd0, m_cfg};
        8'h0C: e_rdata = {18'd0, m_tmo};
        8'h10: e_rdata = {28'd0, core_error, tx_empty, rx_empty, tx_full};
        8'h14: e_rdata = {28'd0, m_en};
        8'h18: e_rdata = {28'd0, m_stat};
        default: e_rdata = '0;
      endcase
    end

    check("PREADY", {31'd0, PREADY}, {31'd0, e_ready});
    check("PSLVERR", {31'd0, PSLVERR}, {31'd0, e_err});
    check("PRDATA", PRDATA, e_rdata);
    check("tx_wr_en", {31'd0, tx_wr_en}, {31'd0, ok && PWRITE && PADDR == 8'h00});
    check("rx_rd_en", {31'd0, rx_rd_en}, {31'd0, ok && !PWRITE && PADDR == 8'h04});
    check("tx_wdata", tx_wdata, PWDATA);
    check("i2c_cfg", {18'd0, i2c_cfg}, {18'd0, m_cfg});
    check("i2c_timeout", {18'd0, i2c_timeout}, {18'd0, m_tmo});
    check("irq", {31'd0, irq}, {31'd0, m_irq});

    if (tx_wr_en) begin
      tx_pulses++;
      last_txw = tx_wdata;
    end
    if (rx_rd_en) rx_pulses++;

    // Model state as it will be after the coming rising edge
    if (PRESETn) begin
      m_irq_nx = |(m_stat & m_en);
      m_clr = '0;
      if (ok && PWRITE) begin
        case (PADDR)
          8'h08: m_cfg = PWDATA[13:0];
          8'h0C: m_tmo = PWDATA[13:0];
          8'h14: m_en  = PWDATA[3:0];
          8'h18: m_clr = PWDATA[3:0];
          default: ;
        endcase
      end
      m_set  = {tmo, core_error && !m_perr, !rx_empty && m_prx, tx_empty && !m_ptx};
      m_stat = (m_stat & ~m_clr) | m_set;
      m_irq  = m_irq_nx;
      m_ptx  = tx_empty;
      m_prx  = rx_empty;
      m_perr = core_error;
      k_cnt  = (acc && !e_ready) ? k_cnt + 1 : 0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic apb(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata, output logic err, output int waits);
    rdata = '0; err = 1'b0; waits = 0;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge PCLK);
      if (PREADY) begin
        rdata = PRDATA;
        err = PSLVERR;
        break;
      end
      waits++;
    end
    if (waits >= 100) check("apb_ready_bound", 32'd0, 32'd1);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic do_wr(input logic [7:0] a, input logic [31:0] d, input logic exp_err,
                       input string nm);
    logic [31:0] r; logic e; int w;
    apb(1'b1, a, d, r, e, w);
    check({nm, "_slverr"}, {31'd0, e}, {31'd0, exp_err});
  endtask

  task automatic do_rd(input logic [7:0] a, input logic [31:0] exp, input logic exp_err,
                       input string nm);
    logic [31:0] r; logic e; int w;
    apb(1'b0, a, 32'd0, r, e, w);
    check(nm, r, exp);
    check({nm, "_slverr"}, {31'd0, e}, {31'd0, exp_err});
  endtask

  logic [31:0] r;
  logic        e;
  int          w, p0;

  initial begin
    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    tx_full = 1'b0; tx_empty = 1'b0; rx_empty = 1'b1; rx_rdata = '0; core_error = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    check("rst_PREADY", {31'd0, PREADY}, 32'd0);
    check("rst_cfg", {18'd0, i2c_cfg}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    PRESETn = 1'b1;

    // CFG / TIMEOUT write and readback with upper bits dropped
    do_wr(8'h08, 32'h3FFF_A5A5, 1'b0, "cfg_wr");
    check("cfg_lit", {18'd0, i2c_cfg}, 32'h0000_25A5);
    do_rd(8'h08, 32'h0000_25A5, 1'b0, "cfg_rd");
    do_wr(8'h0C, 32'hFFFF_0123, 1'b0, "tmo_wr");
    do_rd(8'h0C, 32'h0000_0123, 1'b0, "tmo_rd");

    // TXDATA write stalled three cycles by tx_full
    tx_full = 1'b1;
    p0 = tx_pulses;
    fork
      apb(1'b1, 8'h00, 32'hCAFE_0001, r, e, w);
      begin repeat (5) @(posedge PCLK); #1 tx_full = 1'b0; end
    join
    check("tx_stall_waits", w, 32'd3);
    check("tx_stall_slverr", {31'd0, e}, 32'd0);
    check("tx_stall_pulses", tx_pulses - p0, 32'd1);
    check("tx_stall_wdata", last_txw, 32'hCAFE_0001);

    // RXDATA read that never unstalls: timeout error
    p0 = rx_pulses;
    apb(1'b0, 8'h04, 32'd0, r, e, w);
    check("rx_tmo_waits", w, WAIT_MAX);
    check("rx_tmo_slverr", {31'd0, e}, 32'd1);
    check("rx_tmo_pulses", rx_pulses - p0, 32'd0);
    do_rd(8'h18, 32'h0000_0008, 1'b0, "irqstat_tmo");
    do_wr(8'h18, 32'h0000_0008, 1'b0, "w1c_tmo");
    do_rd(8'h18, 32'h0000_0000, 1'b0, "irqstat_clr");

    // Bad accesses: zero wait, error, no side effects
    do_rd(8'h20, 32'd0, 1'b1, "bad_rd_unmapped");
    do_wr(8'h10, 32'hFFFF_FFFF, 1'b1, "bad_wr_status");
    do_wr(8'h04, 32'h1234_5678, 1'b1, "bad_wr_rxdata");
    do_rd(8'h00, 32'd0, 1'b1, "bad_rd_txdata");
    do_wr(8'h09, 32'h0000_0001, 1'b1, "bad_wr_unaligned");
    do_rd(8'h08, 32'h0000_25A5, 1'b0, "cfg_unchanged");
    do_rd(8'h0C, 32'h0000_0123, 1'b0, "tmo_unchanged");

    // STATUS reflects live FIFO/core levels
    tx_full = 1'b1;
    do_rd(8'h10, 32'h0000_0003, 1'b0, "status_rd");
    tx_full = 1'b0;

    // Successful RX pop plus TXE/RXNE edge events
    rx_rdata = 32'hDEAD_BEEF; rx_empty = 1'b0; tx_empty = 1'b1;
    p0 = rx_pulses;
    do_rd(8'h04, 32'hDEAD_BEEF, 1'b0, "rx_rd");
    check("rx_rd_pulses", rx_pulses - p0, 32'd1);
    do_rd(8'h18, 32'h0000_0003, 1'b0, "irqstat_edges");
    do_wr(8'h18, 32'h0000_0003, 1'b0, "w1c_edges");
    do_rd(8'h18, 32'h0000_0000, 1'b0, "irqstat_edges_clr");
    rx_empty = 1'b1;

    // ERR interrupt: set, registered irq, W1C
    do_wr(8'h14, 32'h0000_0004, 1'b0, "irqen_wr");
    @(posedge PCLK); #1 core_error = 1'b1;
    @(posedge PCLK); #1 check("irq_lat0", {31'd0, irq}, 32'd0);
    @(posedge PCLK); #1 check("irq_lat1", {31'd0, irq}, 32'd1);
    do_wr(8'h18, 32'h0000_0004, 1'b0, "w1c_err");
    check("irq_after_w1c0", {31'd0, irq}, 32'd1);
    @(posedge PCLK); #1 check("irq_after_w1c1", {31'd0, irq}, 32'd0);
    core_error = 1'b0;
    @(posedge PCLK);
    // W1C coinciding with a new ERR edge: set wins
    fork
      apb(1'b1, 8'h18, 32'h0000_0004, r, e, w);
      begin repeat (2) @(posedge PCLK); #1 core_error = 1'b1; end
    join
    do_rd(8'h18, 32'h0000_0004, 1'b0, "irqstat_set_wins");
    check("irq_set_wins", {31'd0, irq}, 32'd1);

    // PSEL dropped mid-wait: no strobe, later transfer still works
    tx_full = 1'b1;
    p0 = tx_pulses;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h00; PWDATA = 32'h0BAD_0BAD;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    repeat (3) @(posedge PCLK);
    #1 PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1 tx_full = 1'b0;
    repeat (3) @(posedge PCLK);
    check("abort_no_pulse", tx_pulses - p0, 32'd0);
    do_wr(8'h00, 32'h0000_0055, 1'b0, "tx_after_abort");
    check("tx_after_abort_pulse", tx_pulses - p0, 32'd1);
    check("tx_after_abort_data", last_txw, 32'h0000_0055);

    // Asynchronous reset in the middle of a stalled RX read
    p0 = rx_pulses;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h04;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    repeat (2) @(negedge PCLK);
    #1 PRESETn = 1'b0;
    #1;
    check("arst_PREADY", {31'd0, PREADY}, 32'd0);
    check("arst_cfg", {18'd0, i2c_cfg}, 32'd0);
    check("arst_tmo", {18'd0, i2c_timeout}, 32'd0);
    check("arst_irq", {31'd0, irq}, 32'd0);
    @(posedge PCLK); #1 PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1 PRESETn = 1'b1;
    check("arst_no_pulse", rx_pulses - p0, 32'd0);
    do_rd(8'h08, 32'h0000_0000, 1'b0, "cfg_after_rst");
    do_rd(8'h14, 32'h0000_0000, 1'b0, "irqen_after_rst");
    repeat (3) @(posedge PCLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global guard so the run always ends
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
